data_mem_ctrl: RTL

Parametrised single-port data memory for the pipelined RISC core, with a request/response handshake, programmable access latency, hardware clear sequencing after reset and out-of-range detection. It sits behind the memory-access stage. Width, depth and wait states are set per instance, so one block serves both the single-cycle model and slower memory models. Each access is a registered transaction with explicit completion pulses, not a combinational read.

---
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with request/response handshake, programmable wait
// states, a clear sweep after reset and out-of-range detection.
//
// state  | meaning
// S_INIT | clear sweep, writes INIT_VAL to one word per cycle
// S_IDLE | ready, accepts one request
// S_WAIT | counting down extra wait states for the latched access
// S_RESP | one-cycle completion pulse (rvalid or wack, plus err)
module data_mem_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 100,
  parameter int                WAIT_CYC = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              init_done,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wack,
  output logic              err
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    clr_cnt;
  logic [3:0]          wait_cnt;
  logic                lat_we, lat_oor;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, commit, init_last;
  logic                cm_we, cm_oor;
  logic [ADDR_W-1:0]   cm_addr;
  logic [DATA_W-1:0]   cm_wdata;
  logic                in_oor;

  assign in_oor = ({1'b0, addr} >= DEPTH_X);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    init_last = (state == S_INIT) && (clr_cnt == CNT_W'(DEPTH - 1));
    case (state)
      S_INIT: if (init_last) state_nxt = S_IDLE;
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            commit    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
    // Zero-wait accesses commit on the accept edge, straight from the inputs.
    if (state == S_IDLE) begin
      cm_we    = we;
      cm_oor   = in_oor;
      cm_addr  = addr;
      cm_wdata = wdata;
    end else begin
      cm_we    = lat_we;
      cm_oor   = lat_oor;
      cm_addr  = lat_addr;
      cm_wdata = lat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= '0;
      wait_cnt  <= '0;
      init_done <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      if (state == S_INIT) clr_cnt <= clr_cnt + CNT_W'(1);
      if (init_last) init_done <= 1'b1;
      if (accept) begin
        lat_we    <= we;
        lat_oor   <= in_oor;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit && !cm_we) rdata <= cm_oor ? '0 : mem[cm_addr[MEM_AW-1:0]];
    end
  end

  // Array has no reset; the clear sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT)
        mem[clr_cnt[MEM_AW-1:0]] <= INIT_VAL;
      else if (commit && cm_we && !cm_oor)
        mem[cm_addr[MEM_AW-1:0]] <= cm_wdata;
    end
  end

  assign ready  = (state == S_IDLE);
  assign rvalid = (state == S_RESP) && !lat_we;
  assign wack   = (state == S_RESP) && lat_we;
  assign err    = (state == S_RESP) && lat_oor;

endmodule
